// File: rtl/combo_lock_ctrl.sv
// combo_lock_ctrl: digit-entry sequencer for the combination lock with code check, lockout and reprogramming
module combo_lock_ctrl #(
    parameter int DIGITS = 4,
    parameter int DW = 4,
    parameter logic [DIGITS*DW-1:0] DEFAULT_CODE = 16'h1234,
    parameter int MAX_FAIL = 3,
    parameter int OPEN_CYC = 500,
    parameter int LOCKOUT_CYC = 1000
) (
    input  logic                            Clock,
    input  logic                            Resetn,
    input  logic [DW-1:0]                   Digit,
    input  logic                            Enter,
    input  logic                            Clear,
    input  logic                            Program,
    output logic                            Unlocked,
    output logic                            Error,
    output logic                            Locked_out,
    output logic [$clog2(DIGITS+1)-1:0]     Count,
    output logic [$clog2(MAX_FAIL+1)-1:0]   Fails
);
    localparam int CW = $clog2(DIGITS + 1);
    localparam int FW = $clog2(MAX_FAIL + 1);
    localparam int TMAX = (OPEN_CYC > LOCKOUT_CYC) ? OPEN_CYC : LOCKOUT_CYC;
    localparam int TW = $clog2(TMAX + 1);
    localparam int SW = (DIGITS - 1) * DW;
    localparam logic [CW-1:0] LAST = CW'(DIGITS - 1);
    localparam logic [FW-1:0] FMAX = FW'(MAX_FAIL);

    typedef enum logic [2:0] {ENTRY, CHECK, FAIL, OPEN, PROG, LOCKOUT} state_t;

    state_t              state, state_next;
    logic [DIGITS*DW-1:0] code;
    logic [SW-1:0]       shadow;
    logic [CW-1:0]       count;
    logic                mismatch;
    logic [FW-1:0]       fails;
    logic [TW-1:0]       timer;
    logic [DW-1:0]       cur_digit;
    logic [FW-1:0]       fails_new;
    logic                last_key;

    // Stored digit at the current entry position; position 0 is the MS digit
    assign cur_digit = DW'(code >> (DW * (DIGITS - 1 - int'(count))));
    assign fails_new = (fails == FMAX) ? fails : fails + FW'(1);
    assign last_key  = Enter && (count == LAST);

    // State register
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) state <= ENTRY;
        else         state <= state_next;
    end

    // Next-state decode
    always_comb begin
        state_next = state;
        case (state)
            ENTRY:   state_next = Clear ? ENTRY : (last_key ? CHECK : ENTRY);
            CHECK:   state_next = !mismatch ? OPEN : ((fails_new == FMAX) ? LOCKOUT : FAIL);
            FAIL:    state_next = ENTRY;
            OPEN:    state_next = Clear ? ENTRY : (Program ? PROG : ((timer == '0) ? ENTRY : OPEN));
            PROG:    state_next = (Clear || last_key) ? ENTRY : PROG;
            LOCKOUT: state_next = (timer == '0) ? ENTRY : LOCKOUT;
            default: state_next = ENTRY;
        endcase
    end

    // Entry counter, mismatch flag, fail counter, timers and code storage
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            code     <= DEFAULT_CODE;
            shadow   <= '0;
            count    <= '0;
            mismatch <= 1'b0;
            fails    <= '0;
            timer    <= '0;
        end else begin
            case (state)
                ENTRY: begin
                    if (Clear) begin
                        count    <= '0;
                        mismatch <= 1'b0;
                    end else if (Enter) begin
                        count    <= count + CW'(1);
                        mismatch <= mismatch | (Digit != cur_digit);
                    end
                end
                CHECK: begin
                    count    <= '0;
                    mismatch <= 1'b0;
                    fails    <= mismatch ? fails_new : '0;
                    timer    <= mismatch ? TW'(LOCKOUT_CYC - 1) : TW'(OPEN_CYC - 1);
                end
                OPEN: begin
                    if (timer != '0) timer <= timer - TW'(1);
                end
                PROG: begin
                    if (Clear) begin
                        count  <= '0;
                        shadow <= '0;
                    end else if (last_key) begin
                        code   <= {shadow, Digit};
                        count  <= '0;
                        shadow <= '0;
                    end else if (Enter) begin
                        count  <= count + CW'(1);
                        shadow <= SW'({shadow, Digit});
                    end
                end
                LOCKOUT: begin
                    if (timer == '0) fails <= '0;
                    else             timer <= timer - TW'(1);
                end
                default: ;
            endcase
        end
    end

    // Moore output decode
    always_comb begin
        Unlocked   = (state == OPEN);
        Error      = (state == FAIL);
        Locked_out = (state == LOCKOUT);
        Count      = count;
        Fails      = fails;
    end
endmodule

// File: tb/tb_combo_lock_ctrl.sv
// tb_combo_lock_ctrl: scoreboard bench for combo_lock_ctrl code entry, lockout and programming
module tb_combo_lock_ctrl;
    localparam int OPEN_CYC = 500;
    localparam int LOCKOUT_CYC = 1000;
    localparam logic [2:0] UNL = 3'b001;
    localparam logic [2:0] ERR = 3'b010;
    localparam logic [2:0] LCK = 3'b100;

    logic       Clock = 1'b0;
    logic       Resetn = 1'b0;
    logic       Enter = 1'b0;
    logic       Clear = 1'b0;
    logic       Program = 1'b0;
    logic [3:0] Digit = '0;
    logic       Unlocked, Error, Locked_out;
    logic [2:0] Count;
    logic [1:0] Fails;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [2:0] ind;
        logic [1:0] fails;
    } exp_t;
    exp_t sb[$];

    combo_lock_ctrl dut (
        .Clock(Clock), .Resetn(Resetn), .Digit(Digit), .Enter(Enter), .Clear(Clear),
        .Program(Program), .Unlocked(Unlocked), .Error(Error), .Locked_out(Locked_out),
        .Count(Count), .Fails(Fails)
    );

    always #5 Clock = ~Clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    function automatic int dur_of(input logic [2:0] ind);
        return (ind == UNL) ? OPEN_CYC : ((ind == ERR) ? 1 : LOCKOUT_CYC);
    endfunction

    task automatic key(input logic [3:0] d);
        Enter = 1'b1;
        Digit = d;
        tick();
        Enter = 1'b0;
    endtask

    task automatic attempt(input logic [15:0] c, input logic [2:0] ind, input logic [1:0] f,
                           input bit measure, input bit inject);
        exp_t e;
        int lat;
        int dur;
        bit bad_unl;
        bit bad_cnt;
        sb.push_back('{ind, f});
        for (int i = 0; i < 4; i++) begin
            key(c[15-4*i -: 4]);
            if (i < 3) check("count_step", 32'(Count), i + 1);
        end
        lat = 0;
        while (!(Unlocked || Error || Locked_out) && lat < 10) begin
            tick();
            lat++;
        end
        e = sb.pop_front();
        check("latency", lat, 1);
        check("indicator", 32'({Locked_out, Error, Unlocked}), 32'(e.ind));
        check("fails", 32'(Fails), 32'(e.fails));
        if (measure) begin
            dur = 0;
            bad_unl = 1'b0;
            bad_cnt = 1'b0;
            while ((({Locked_out, Error, Unlocked} & e.ind) != 3'b000) && dur < 2000) begin
                dur++;
                if (inject && dur >= 10 && dur < 14) begin
                    Enter = 1'b1;
                    Digit = 4'(dur - 9);
                end
                tick();
                Enter = 1'b0;
                bad_unl |= Unlocked && !e.ind[0];
                bad_cnt |= (Count != 3'd0);
            end
            check("duration", dur, dur_of(e.ind));
            if (inject) begin
                check("lockout_no_unlock", 32'(bad_unl), 0);
                check("lockout_no_count", 32'(bad_cnt), 0);
            end
            check("idle_after", 32'({Locked_out, Error, Unlocked, Count}), 0);
        end
    endtask

    initial begin
        #1;
        check("reset_outputs", 32'({Unlocked, Error, Locked_out, Count, Fails}), 0);
        #11 Resetn = 1'b1;
        tick();
        check("post_reset", 32'({Unlocked, Error, Locked_out, Count, Fails}), 0);

        attempt(16'h1234, UNL, 2'd0, 1'b1, 1'b0);
        attempt(16'h1235, ERR, 2'd1, 1'b1, 1'b0);
        attempt(16'h1111, ERR, 2'd2, 1'b1, 1'b0);
        attempt(16'h4321, LCK, 2'd3, 1'b1, 1'b1);
        check("fails_cleared", 32'(Fails), 0);
        attempt(16'h1234, UNL, 2'd0, 1'b1, 1'b0);

        attempt(16'h1234, UNL, 2'd0, 1'b0, 1'b0);
        Program = 1'b1;
        tick();
        check("prog_entered", 32'(Unlocked), 0);
        key(4'h9);
        check("prog_count1", 32'(Count), 1);
        key(4'h8);
        check("prog_count2", 32'(Count), 2);
        Program = 1'b0;
        key(4'h7);
        check("prog_count3", 32'(Count), 3);
        key(4'h6);
        check("prog_commit", 32'({Unlocked, Count}), 0);
        attempt(16'h1234, ERR, 2'd1, 1'b1, 1'b0);
        attempt(16'h9876, UNL, 2'd0, 1'b0, 1'b0);
        Resetn = 1'b0;
        #2;
        check("async_reset", 32'({Unlocked, Error, Locked_out, Count, Fails}), 0);
        Resetn = 1'b1;
        tick();
        attempt(16'h1234, UNL, 2'd0, 1'b1, 1'b0);

        key(4'h1);
        key(4'h2);
        check("partial_count", 32'(Count), 2);
        Enter = 1'b1;
        Digit = 4'h3;
        Clear = 1'b1;
        tick();
        Enter = 1'b0;
        Clear = 1'b0;
        check("clear_wins", 32'(Count), 0);
        attempt(16'h1234, UNL, 2'd0, 1'b0, 1'b0);
        for (int i = 0; i < 9; i++) tick();
        check("open_at_10", 32'(Unlocked), 1);
        Clear = 1'b1;
        tick();
        Clear = 1'b0;
        check("open_clear", 32'({Unlocked, Count}), 0);

        attempt(16'h1234, UNL, 2'd0, 1'b0, 1'b0);
        Program = 1'b1;
        tick();
        Program = 1'b0;
        key(4'h9);
        key(4'h8);
        check("prog_partial", 32'(Count), 2);
        Clear = 1'b1;
        tick();
        Clear = 1'b0;
        check("prog_abort", 32'({Unlocked, Count}), 0);
        attempt(16'h9876, ERR, 2'd1, 1'b1, 1'b0);
        attempt(16'h1234, UNL, 2'd0, 1'b1, 1'b0);

        check("sb_empty", 32'(sb.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/combo_lock_ctrl.md
# combo_lock_ctrl

Sequencing controller for the combination lock. It consumes the single-cycle `Enter` and `Clear` pulses produced by the input conditioners, plus the digit switches. It collects a DIGITS-long code, compares it against a stored code, and drives the unlock, error and lockout indicators. It also supports reprogramming the stored code while the lock is open.

## Interface
Parameters:
- DIGITS, 4: code length in digits.
- DW, 4: digit width in bits.
- DEFAULT_CODE, 16'h1234: reset value of the stored code, DIGITS*DW bits. The first digit entered is the MS digit.
- MAX_FAIL, 3: consecutive failed attempts that trigger lockout.
- OPEN_CYC, 500: cycles `Unlocked` stays high.
- LOCKOUT_CYC, 1000: cycles `Locked_out` stays high.

Ports:
- Clock, in, 1: system clock, rising edge.
- Resetn, in, 1: one clock; reset is asynchronous and active-low.
- Digit, in, DW: digit value, sampled only in cycles where `Enter`=1.
- Enter, in, 1: single-cycle pulse from the input conditioner that accepts `Digit`.
- Clear, in, 1: single-cycle pulse that aborts the current entry or programming, or relocks.
- Program, in, 1: level; requests code programming. Honoured only in OPEN.
- Unlocked, out, 1: high while in OPEN.
- Error, out, 1: high for exactly one cycle on a failed attempt.
- Locked_out, out, 1: high while in LOCKOUT.
- Count, out, clog2(DIGITS+1): digits accepted so far in the current entry or programming pass.
- Fails, out, clog2(MAX_FAIL+1): consecutive failed attempts.

## Operation
- States: ENTRY, CHECK, FAIL, OPEN, PROG, LOCKOUT. All outputs are Moore-decoded from registered state and counters.
- Reset (async, Resetn=0):
  - state goes to ENTRY, the stored code to DEFAULT_CODE, and every counter and flag to 0.
  - Unlocked, Error, Locked_out, Count and Fails are all 0.
- ENTRY:
  - Each `Enter` sets `mismatch |= (Digit != code digit[Count])` and increments Count. Digit index 0 is the MS digit.
  - When Count would reach DIGITS, the next state is CHECK.
  - `Clear` sets Count=0 and mismatch=0. Fails is unchanged.
  - If `Clear` and `Enter` arrive in the same cycle, `Clear` wins and the digit is dropped.
- CHECK (1 cycle):
  - Count and mismatch are cleared in all cases.
  - If mismatch=0, go to OPEN and set Fails=0.
  - Otherwise increment Fails (saturating). If the new Fails equals MAX_FAIL, go to LOCKOUT; otherwise go to FAIL.
- FAIL (1 cycle): Error=1, then go to ENTRY.
- OPEN:
  - The timer counts OPEN_CYC cycles, then the state returns to ENTRY.
  - `Clear` returns to ENTRY immediately.
  - `Program`=1 (with no `Clear`) goes to PROG, and the timer stops.
  - `Enter` is ignored.
- PROG:
  - Each `Enter` writes `Digit` into the shadow code at index Count and increments Count.
  - On the DIGITS-th `Enter`, the shadow code is committed to the stored code, Count=0, and the state goes to ENTRY (locked).
  - `Clear` discards the shadow code, sets Count=0 and goes to ENTRY. The stored code is unchanged.
  - Deasserting `Program` mid-pass does not abort it.
- LOCKOUT:
  - All inputs are ignored.
  - After LOCKOUT_CYC cycles: Fails=0, state goes to ENTRY.
- Widths:
  - Timers are clog2(max(OPEN_CYC, LOCKOUT_CYC)+1) bits and are reloaded on entry to OPEN or LOCKOUT.
  - Count never exceeds DIGITS-1 while visible in ENTRY or PROG.
- Async reset mid-operation (any state, including PROG) restores DEFAULT_CODE and discards any partial entry.

## Timing
- An `Enter` sampled at edge k is reflected in Count after edge k.
- Final digit at edge k:
  - CHECK after edge k.
  - OPEN, FAIL or LOCKOUT after edge k+1.
  - Unlocked, Error or Locked_out become visible 2 cycles after the final `Enter`.
- Unlocked is high for exactly OPEN_CYC cycles unless cut short by `Clear` or `Program`.
- Locked_out is high for exactly LOCKOUT_CYC cycles.
- Error is high for exactly 1 cycle.
- Back-to-back `Enter` pulses in consecutive cycles are all accepted in ENTRY and PROG.
- An `Enter` arriving in CHECK or FAIL is dropped.
- A programming commit at edge k takes effect for comparisons from edge k+1 onward.

## Test plan
- Reset, then `Enter` 1,2,3,4 on consecutive cycles → CHECK, then Unlocked=1 for 500 cycles, then ENTRY; Fails=0; Error never asserted.
- Enter 1,2,3,5 → Error=1 for one cycle 2 cycles after the last digit; Fails=1; Count=0; Unlocked stays 0.
- Three wrong codes → Fails reaches 3, Locked_out=1 for 1000 cycles; a correct code entered during lockout is ignored; afterwards Fails=0 and 1,2,3,4 unlocks.
- In OPEN, hold Program=1, enter 9,8,7,6 → state ENTRY; 1,2,3,4 now fails and 9,8,7,6 unlocks. Pulse Resetn low → 1,2,3,4 unlocks again.
- Enter 1,2 then `Clear` coincident with `Enter` of 3 → Count=0 with the digit dropped; then 1,2,3,4 unlocks.
- In OPEN at cycle 10, pulse `Clear` → Unlocked=0 after the next edge; in PROG after 2 digits, `Clear` → stored code unchanged (1,2,3,4 still unlocks).
